// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, memory
// access codes, FSM state encodings and the captured-request context.
package lsu_pkg;

    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_OP_W   = 3;
    localparam int unsigned LSU_RD_W   = 5;
    localparam int unsigned LSU_CODE_W = 2;
    localparam int unsigned LSU_ST_W   = 2;

    localparam logic [LSU_OP_W-1:0] OP_LB  = 3'd0;
    localparam logic [LSU_OP_W-1:0] OP_LBU = 3'd1;
    localparam logic [LSU_OP_W-1:0] OP_LW  = 3'd2;
    localparam logic [LSU_OP_W-1:0] OP_SB  = 3'd3;
    localparam logic [LSU_OP_W-1:0] OP_SW  = 3'd4;

    localparam logic [LSU_CODE_W-1:0] MEM_NONE = 2'b00;
    localparam logic [LSU_CODE_W-1:0] MEM_BYTE = 2'b01;
    localparam logic [LSU_CODE_W-1:0] MEM_WORD = 2'b11;

    localparam logic [LSU_ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [LSU_ST_W-1:0] ST_ISSUE   = 2'd1;
    localparam logic [LSU_ST_W-1:0] ST_CAPTURE = 2'd2;

    // Context kept from accept until the load result is written back
    typedef struct packed {
        logic [LSU_OP_W-1:0] op;
        logic [LSU_RD_W-1:0] rd;
    } lsu_ctx_t;

    function automatic logic is_store(input logic [LSU_OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SW);
    endfunction

    function automatic logic is_word(input logic [LSU_OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [LSU_CODE_W-1:0] size_code(input logic [LSU_OP_W-1:0] op);
        return is_word(op) ? MEM_WORD : MEM_BYTE;
    endfunction

endpackage

// File: rtl/load_store_unit_formatter.sv
// Load result formatting: sign/zero extension of the byte lane for LB/LBU,
// word passthrough otherwise.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [LSU_OP_W-1:0]   op,
    input  logic [LSU_DATA_W-1:0] rdata,
    output logic [LSU_DATA_W-1:0] data_c
);

    always_comb begin
        data_c = rdata;
        case (op)
            OP_LB:   data_c = {{(LSU_DATA_W-8){rdata[7]}}, rdata[7:0]};
            OP_LBU:  data_c = LSU_DATA_W'(rdata[7:0]);
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage sequencer: accepts one load/store at a time, rejects misaligned or
// out-of-range requests, drives the data memory and returns formatted load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic [LSU_OP_W-1:0]     req_op,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LSU_DATA_W-1:0]   req_wdata,
    input  logic [LSU_RD_W-1:0]     req_rd,
    output logic                    req_ready,
    output logic                    stall,
    output logic [LSU_CODE_W-1:0]   mem_read,
    output logic [LSU_CODE_W-1:0]   mem_write,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LSU_DATA_W-1:0]   mem_wdata,
    input  logic [LSU_DATA_W-1:0]   mem_rdata,
    output logic                    wb_valid,
    output logic [LSU_RD_W-1:0]     wb_rd,
    output logic [LSU_DATA_W-1:0]   wb_data,
    output logic                    fault,
    output logic [ADDR_W-1:0]       fault_addr
);

    localparam int unsigned AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] MEM_LIMIT = AW1'(MEM_BYTES);

    logic [LSU_ST_W-1:0]   state_q;
    logic [LSU_ST_W-1:0]   state_d;
    lsu_ctx_t              ctx_q;
    lsu_ctx_t              ctx_d;
    logic                  ready_d;
    logic [LSU_CODE_W-1:0] mem_read_d;
    logic [LSU_CODE_W-1:0] mem_write_d;
    logic [ADDR_W-1:0]     mem_addr_d;
    logic [LSU_DATA_W-1:0] mem_wdata_d;
    logic                  wb_valid_d;
    logic [LSU_RD_W-1:0]   wb_rd_d;
    logic [LSU_DATA_W-1:0] wb_data_d;
    logic                  fault_d;
    logic [ADDR_W-1:0]     fault_addr_d;
    logic [LSU_DATA_W-1:0] fmt_data;
    logic [AW1-1:0]        addr_ext;
    logic [AW1-1:0]        addr_last;
    logic                  req_legal;

    load_formatter u_load_formatter (
        .op     (ctx_q.op),
        .rdata  (mem_rdata),
        .data_c (fmt_data)
    );

    // One extra address bit so addr+3 cannot wrap past the memory limit
    assign addr_ext  = {1'b0, req_addr};
    assign addr_last = addr_ext + AW1'(3);

    always_comb begin
        req_legal = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: req_legal = (addr_ext < MEM_LIMIT);
            OP_LW, OP_SW:         req_legal = (req_addr[1:0] == 2'b00) && (addr_last < MEM_LIMIT);
            default:              req_legal = 1'b0;
        endcase
    end

    assign stall = req_valid & ~req_ready;

    always_comb begin
        state_d      = state_q;
        ctx_d        = ctx_q;
        mem_read_d   = MEM_NONE;
        mem_write_d  = MEM_NONE;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd;
        wb_data_d    = wb_data;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_legal) begin
                        fault_d      = 1'b1;
                        fault_addr_d = req_addr;
                    end else begin
                        ctx_d      = '{op: req_op, rd: req_rd};
                        mem_addr_d = req_addr;
                        if (is_store(req_op)) begin
                            mem_write_d = size_code(req_op);
                            mem_wdata_d = (req_op == OP_SB) ? LSU_DATA_W'(req_wdata[7:0]) : req_wdata;
                        end else begin
                            mem_read_d  = size_code(req_op);
                            mem_wdata_d = '0;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = is_store(ctx_q.op) ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                wb_valid_d = 1'b1;
                wb_rd_d    = ctx_q.rd;
                wb_data_d  = fmt_data;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctx_q      <= '0;
            req_ready  <= 1'b1;
            mem_read   <= MEM_NONE;
            mem_write  <= MEM_NONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            req_ready  <= ready_d;
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            wb_valid   <= wb_valid_d;
            wb_rd      <= wb_rd_d;
            wb_data    <= wb_data_d;
            fault      <= fault_d;
            fault_addr <= fault_addr_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a big-endian data memory, a cycle-level reference
// model of the unit, a per-cycle comparator, directed cases and random traffic.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEMB          = 64;
    localparam int RANDOM_CYCLES = 1500;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op    = 3'd0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd    = 5'd0;
    logic        req_ready;
    logic        stall;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [31:0] fault_addr;

    bit          init_done = 1'b0;
    int          checks    = 0;
    int          failures  = 0;
    int unsigned tb_cyc    = 0;

    load_store_unit #(.MEM_BYTES(64), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .req_ready  (req_ready),
        .stall      (stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    function automatic logic [7:0] seed_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory seen by the unit: big-endian words, registered read port
    logic [7:0] env_mem [MEMB];
    always @(posedge clk) begin : env_memory
        int a;
        a = int'(mem_addr[5:0]);
        if (!init_done) begin
            for (int i = 0; i < MEMB; i++) env_mem[i] <= seed_byte(i);
        end else begin
            if (mem_write == MEM_WORD) begin
                for (int i = 0; i < 4; i++) env_mem[(a + i) % MEMB] <= mem_wdata[31 - 8 * i -: 8];
            end else if (mem_write == MEM_BYTE) begin
                env_mem[a] <= mem_wdata[7:0];
            end
            if (mem_read == MEM_WORD) begin
                mem_rdata <= {env_mem[a], env_mem[(a + 1) % MEMB], env_mem[(a + 2) % MEMB], env_mem[(a + 3) % MEMB]};
            end else if (mem_read == MEM_BYTE) begin
                mem_rdata <= {24'h0, env_mem[a]};
            end
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [MEMB];
    int          m_cyc;
    int          m_next_free;
    bit          p_valid;
    logic [2:0]  p_op;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [4:0]  p_rd;
    int          p_edge;
    bit          l_valid;
    logic [31:0] l_data;
    logic [4:0]  l_rd;
    int          l_due;
    logic [1:0]  e_read;
    logic [1:0]  e_write;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    bit          e_fault;
    logic [31:0] e_faddr;
    bit          e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    bit          e_ready;

    function automatic bit ref_legal(input logic [2:0] op, input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        case (op)
            OP_LB, OP_LBU, OP_SB: return a < MEMB;
            OP_LW, OP_SW:         return (a % 4 == 0) && (a + 3 < MEMB);
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
        int a;
        int b;
        a = int'(addr);
        b = int'(ref_mem[a]);
        if (op == OP_LW)
            return 32'(b * 16777216 + int'(ref_mem[a + 1]) * 65536 + int'(ref_mem[a + 2]) * 256 + int'(ref_mem[a + 3]));
        if (op == OP_LB && b >= 128) return 32'(b - 256);
        return 32'(b);
    endfunction

    task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int a;
        a = int'(addr);
        if (op == OP_SW) begin
            for (int i = 0; i < 4; i++) ref_mem[a + i] = 8'(wdata >> (8 * (3 - i)));
        end else begin
            ref_mem[a] = 8'(wdata);
        end
    endtask

    // Occupancy model: a fault frees the unit after 1 edge, a store after 2, a load after 3
    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            m_cyc = 0; m_next_free = 0; p_valid = 0; l_valid = 0;
            e_read = MEM_NONE; e_write = MEM_NONE; e_fault = 0; e_wb = 0; e_ready = 1;
            if (!init_done) for (int i = 0; i < MEMB; i++) ref_mem[i] = seed_byte(i);
        end else begin
            m_cyc++;
            e_read = MEM_NONE; e_write = MEM_NONE; e_fault = 0; e_wb = 0;
            if (p_valid && m_cyc == p_edge + 1) begin
                if (p_op == OP_SB || p_op == OP_SW) begin
                    ref_store(p_op, p_addr, p_wdata);
                end else begin
                    l_valid = 1; l_data = ref_load(p_op, p_addr); l_rd = p_rd; l_due = m_cyc + 1;
                end
                p_valid = 0;
            end
            if (l_valid && m_cyc == l_due) begin
                e_wb = 1; e_data = l_data; e_rd = l_rd; l_valid = 0;
            end
            if (req_valid && m_cyc >= m_next_free) begin
                if (!ref_legal(req_op, req_addr)) begin
                    e_fault = 1; e_faddr = req_addr; m_next_free = m_cyc + 1;
                end else begin
                    p_valid = 1; p_op = req_op; p_addr = req_addr; p_wdata = req_wdata; p_rd = req_rd;
                    p_edge = m_cyc; e_addr = req_addr;
                    if (req_op == OP_SB || req_op == OP_SW) begin
                        e_write = (req_op == OP_SW) ? MEM_WORD : MEM_BYTE;
                        e_wdata = (req_op == OP_SW) ? req_wdata : (req_wdata & 32'hFF);
                        m_next_free = m_cyc + 2;
                    end else begin
                        e_read = (req_op == OP_LW) ? MEM_WORD : MEM_BYTE;
                        m_next_free = m_cyc + 3;
                    end
                end
            end
            e_ready = (m_cyc + 1 >= m_next_free);
        end
    end

    always @(negedge clk) begin : compare
        if (rst_n && init_done) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("stall", 32'(stall), 32'(req_valid & ~e_ready));
            chk("mem_read", 32'(mem_read), 32'(e_read));
            chk("mem_write", 32'(mem_write), 32'(e_write));
            if (e_read != MEM_NONE || e_write != MEM_NONE) chk("mem_addr", mem_addr, e_addr);
            if (e_write != MEM_NONE) chk("mem_wdata", mem_wdata, e_wdata);
            chk("fault", 32'(fault), 32'(e_fault));
            if (e_fault) chk("fault_addr", fault_addr, e_faddr);
            chk("wb_valid", 32'(wb_valid), 32'(e_wb));
            if (e_wb) begin
                chk("wb_rd", 32'(wb_rd), 32'(e_rd));
                chk("wb_data", wb_data, e_data);
            end
            chk("rw_exclusive", 32'(mem_read != MEM_NONE && mem_write != MEM_NONE), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a request and hold it until the edge that accepts it
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        bit r;
        bit ok;
        ok = 0;
        req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        for (int n = 0; n < 20; n++) begin
            r = req_ready;
            @(posedge clk);
            #2;
            if (r) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: op %0d addr 0x%08h not accepted within 20 cycles", op, addr);
        end
    endtask

    task automatic wait_wb(input string name, input logic [31:0] lit, input logic [4:0] rd);
        int n;
        bit found;
        found = 0;
        n = 0;
        while (n < 8 && !found) begin
            @(negedge clk);
            if (wb_valid) found = 1;
            else n++;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s_timeout: wb_valid not seen within 8 cycles", name);
        end else begin
            chk({name, "_latency"}, 32'(n), 32'd2);
            chk({name, "_data"}, wb_data, lit);
            chk({name, "_rd"}, 32'(wb_rd), 32'(rd));
            chk({name, "_model"}, e_data, lit);
        end
        tick();
    endtask

    task automatic expect_fault(input string name, input logic [2:0] op, input logic [31:0] addr);
        send(op, addr, 32'h0, 5'd9);
        req_valid = 0;
        @(negedge clk);
        chk({name, "_fault"}, 32'(fault), 32'd1);
        chk({name, "_fault_addr"}, fault_addr, addr);
        chk({name, "_no_read"}, 32'(mem_read), 32'(MEM_NONE));
        repeat (3) begin
            @(negedge clk);
            chk({name, "_no_wb"}, 32'(wb_valid), 32'd0);
            chk({name, "_fault_pulse"}, 32'(fault), 32'd0);
        end
        tick();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned t1;
        int unsigned t2;
        int unsigned t3;
        logic [31:0] a;

        repeat (2) @(posedge clk);
        #2 init_done = 1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        @(posedge clk);
        #2 rst_n = 1;
        tick();

        // Word store then word load
        send(OP_SW, 32'd8, 32'hDEADBEEF, 5'd0);
        req_valid = 0;
        @(negedge clk);
        chk("sw8_mem_write", 32'(mem_write), 32'(MEM_WORD));
        chk("sw8_mem_addr", mem_addr, 32'd8);
        chk("sw8_mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw8_write_drop", 32'(mem_write), 32'(MEM_NONE));
        tick();
        send(OP_LW, 32'd8, 32'h0, 5'd3);
        req_valid = 0;
        wait_wb("lw8", 32'hDEADBEEF, 5'd3);

        // Byte store, signed and unsigned byte loads
        send(OP_SB, 32'd5, 32'h12345680, 5'd0);
        req_valid = 0;
        @(negedge clk);
        chk("sb5_mem_write", 32'(mem_write), 32'(MEM_BYTE));
        chk("sb5_mem_wdata", mem_wdata, 32'h00000080);
        tick();
        send(OP_LB, 32'd5, 32'h0, 5'd4);
        req_valid = 0;
        wait_wb("lb5", 32'hFFFFFF80, 5'd4);
        send(OP_LBU, 32'd5, 32'h0, 5'd6);
        req_valid = 0;
        wait_wb("lbu5", 32'h00000080, 5'd6);

        // Rejected requests and the range boundary
        expect_fault("lw6", OP_LW, 32'd6);
        expect_fault("lw62", OP_LW, 32'd62);
        expect_fault("lb64", OP_LB, 32'd64);
        send(OP_SW, 32'd60, 32'h01020304, 5'd0);
        req_valid = 0;
        repeat (2) tick();
        send(OP_LB, 32'd63, 32'h0, 5'd8);
        req_valid = 0;
        wait_wb("lb63", 32'h00000004, 5'd8);

        // Back-to-back with req_valid held throughout
        send(OP_SW, 32'd16, 32'hCAFEF00D, 5'd0);
        req_valid = 0;
        repeat (2) tick();
        send(OP_LW, 32'd8, 32'h0, 5'd1);
        t1 = tb_cyc;
        send(OP_LW, 32'd16, 32'h0, 5'd2);
        t2 = tb_cyc;
        send(OP_SW, 32'd20, 32'h0BADC0DE, 5'd0);
        t3 = tb_cyc;
        req_valid = 0;
        chk("b2b_lw_gap", 32'(t2 - t1), 32'd3);
        chk("b2b_sw_gap", 32'(t3 - t2), 32'd3);
        tick();
        send(OP_LW, 32'd20, 32'h0, 5'd5);
        req_valid = 0;
        wait_wb("lw20", 32'h0BADC0DE, 5'd5);

        // Reset while a store is in ISSUE must suppress the write
        send(OP_SW, 32'd12, 32'hA5A55A5A, 5'd0);
        req_valid = 0;
        repeat (2) tick();
        send(OP_SW, 32'd12, 32'h11223344, 5'd0);
        req_valid = 0;
        rst_n = 0;
        #1;
        chk("rst_issue_write_drop", 32'(mem_write), 32'(MEM_NONE));
        chk("rst_issue_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1;
        tick();
        send(OP_LW, 32'd12, 32'h0, 5'd7);
        req_valid = 0;
        wait_wb("lw12_after_rst", 32'hA5A55A5A, 5'd7);

        // Random traffic with occasional asynchronous reset pulses
        for (int c = 0; c < RANDOM_CYCLES; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_op    = 3'($urandom_range(0, 7));
            a         = 32'($urandom_range(0, 70));
            if ((req_op == OP_LW || req_op == OP_SW) && $urandom_range(0, 9) < 7) a = a & ~32'd3;
            req_addr  = a;
            req_wdata = $urandom();
            req_rd    = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 0;
                #2 rst_n = 1;
            end
            tick();
        end
        req_valid = 0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
